prog_loader: RTL
================

Name: prog_loader

Overview:
- Writer side of the instruction-memory interface: receives a framed byte stream and writes 16-bit instruction words into the 32-word instruction memory that the processor fetches from.
- Holds the processor stopped (cpu_hold) until a complete frame with a valid checksum has been written.
- Sits between the external byte source (switches/serial front end) and the instruction memory's write port.

Parameters:
- ADDR_W, 5, instruction memory address width.
- DEPTH, 32, maximum words per frame; must be ≤ 2^ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; re-arms loader from S_DONE or S_ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte this cycle; a byte transfers when in_valid && in_ready.
- mem_addr  out  ADDR_W  instruction memory write address.
- mem_data  out  16  instruction word to write.
- mem_wren  out  1  one-cycle write strobe.
- cpu_hold  out  1  1 = processor must stay stopped.
- done  out  1  frame loaded and checksum good; level.
- error  out  1  frame rejected; level.

Behaviour:
- Frame format: SYNC_BYTE, N (word count), N × {high byte, low byte}, CHK. CHK is the XOR of all 2N data bytes; SYNC_BYTE and N are excluded from CHK.
- Reset (synchronous, active-high), including mid-frame:
  - state = S_SYNC; in_ready = 1; mem_addr = 0; mem_data = 0; mem_wren = 0; cpu_hold = 1; done = 0; error = 0; word counter = 0; checksum accumulator = 0.
  - Reset overrides start and any byte transfer in the same cycle.
- States and transitions:
  - S_SYNC: accepted byte == SYNC_BYTE → S_COUNT; any other accepted byte is discarded and the state stays S_SYNC.
  - S_COUNT: accepted byte N. If N == 0 or N > DEPTH → S_ERR. Otherwise latch N, clear word counter and checksum → S_HI.
  - S_HI: accepted byte → mem_data[15:8]; XOR into checksum → S_LO.
  - S_LO: accepted byte → mem_data[7:0]; XOR into checksum → S_WR.
  - S_WR: in_ready = 0; mem_wren = 1 for exactly this cycle; mem_addr = word counter; mem_data stable. Next: increment word counter. If the new count == N → S_CHK, else → S_HI.
  - S_CHK: accepted byte compared with the accumulated checksum. Equal → S_DONE; unequal → S_ERR.
  - S_DONE: done = 1; cpu_hold = 0; in_ready = 0.
  - S_ERR: error = 1; cpu_hold = 1; in_ready = 0.
- in_ready:
  - 1 in S_SYNC, S_COUNT, S_HI, S_LO, S_CHK.
  - 0 in S_WR, S_DONE, S_ERR.
  - Combinational from state only; never depends on in_valid.
- Bytes are consumed only on in_valid && in_ready. With in_valid low, the state holds indefinitely; there is no timeout.
- Throughput: one word per 3 cycles minimum (HI, LO, WR).
- mem_wren:
  - Asserted only in S_WR; never two consecutive cycles.
  - mem_addr wraps naturally in ADDR_W bits; the N ≤ DEPTH check prevents overrun.
- Words written before an S_ERR remain in memory. cpu_hold stays 1, so they are never executed.
- start in S_DONE or S_ERR:
  - Next state S_SYNC; done = 0; error = 0; cpu_hold = 1; counters cleared.
  - start is ignored in all other states.
- done and error are never both 1.
- cpu_hold rises on the same edge that leaves S_DONE.

Test Plan:
1. Reset, then stream A5, 02, 12, 34, AB, CD, checksum 12^34^AB^CD = 40 → two mem_wren pulses: (addr 0, 16'h1234), then (addr 1, 16'hABCD). Then done = 1, cpu_hold = 0, error = 0, in_ready = 0.
2. Same frame with CHK = 41 → both words written; error = 1, done = 0, cpu_hold = 1. Then pulse start → state S_SYNC, error = 0, in_ready = 1.
3. Leading garbage 00, FF, 5A, then a valid 1-word frame A5, 01, 00, 07, 07 → garbage causes no writes; one write (addr 0, 16'h0007); done = 1.
4. Bad count: A5, 00 → error = 1 with no mem_wren. After start, A5, 21 (33 > DEPTH) → error = 1 with no mem_wren.
5. Full frame: N = 32 with in_valid toggled randomly, words 16'h0100 + i → 32 writes to addr 0..31 with matching data. mem_wren is never high on consecutive cycles and in_ready is 0 on every write cycle. done = 1.
6. Assert reset after the high byte of word 1 of a 3-word frame → next cycle all outputs are at reset values and state is S_SYNC. A fresh valid frame then loads from addr 0 and done = 1.

Source files
------------

// File: rtl/prog_loader.sv
// Instruction-memory loader: parses a framed byte stream (sync, count, word bytes, XOR checksum)
// and writes 16-bit words into instruction memory, releasing cpu_hold only after a good frame.
module prog_loader #(
   parameter int         ADDR_W    = 5,
   parameter int         DEPTH     = 32,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic              mem_wren,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_SYNC,
      S_COUNT,
      S_HI,
      S_LO,
      S_WR,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W:0]   word_cnt;
   logic [ADDR_W:0]   word_max;
   logic [ADDR_W:0]   word_nxt;
   logic [7:0]        chk;
   logic [15:0]       word_reg;
   logic              take;
   logic              count_bad;

   assign take      = in_valid && in_ready;
   assign word_nxt  = word_cnt + {{ADDR_W{1'b0}}, 1'b1};
   // Compare in 32 bits so counts above DEPTH are caught even when DEPTH fills ADDR_W.
   assign count_bad = (in_data == 8'd0) || ({24'd0, in_data} > 32'(DEPTH));

   assign mem_addr  = word_cnt[ADDR_W-1:0];
   assign mem_data  = word_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_SYNC;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_SYNC:  if (take && in_data == SYNC_BYTE) next_state = S_COUNT;
         S_COUNT: if (take) next_state = count_bad ? S_ERR : S_HI;
         S_HI:    if (take) next_state = S_LO;
         S_LO:    if (take) next_state = S_WR;
         S_WR:    next_state = (word_nxt == word_max) ? S_CHK : S_HI;
         S_CHK:   if (take) next_state = (in_data == chk) ? S_DONE : S_ERR;
         S_DONE:  if (start) next_state = S_SYNC;
         S_ERR:   if (start) next_state = S_SYNC;
         default: next_state = S_SYNC;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      mem_wren = 1'b0;
      cpu_hold = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
      case (state)
         S_SYNC, S_COUNT, S_HI, S_LO, S_CHK: in_ready = 1'b1;
         S_WR:    mem_wren = 1'b1;
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         S_ERR:   error = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         word_cnt <= '0;
         word_max <= '0;
         chk      <= 8'd0;
         word_reg <= 16'd0;
      end else begin
         case (state)
            S_COUNT: begin
               if (take && !count_bad) begin
                  word_max <= in_data[ADDR_W:0];
                  word_cnt <= '0;
                  chk      <= 8'd0;
               end
            end
            S_HI: begin
               if (take) begin
                  word_reg[15:8] <= in_data;
                  chk            <= chk ^ in_data;
               end
            end
            S_LO: begin
               if (take) begin
                  word_reg[7:0] <= in_data;
                  chk           <= chk ^ in_data;
               end
            end
            S_WR: word_cnt <= word_nxt;
            S_DONE, S_ERR: begin
               if (start) begin
                  word_cnt <= '0;
                  word_max <= '0;
                  chk      <= 8'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
